// File: rtl/collision_avoidance.sv
// Bump-and-turn motor controller: filters the crash flag, sequences a
// brake / reverse / spin-turn manoeuvre and drives two PWM H-bridge channels.
module collision_avoidance #(
  parameter int PWM_PERIOD     = 1000,
  parameter int CRASH_FILTER   = 4,
  parameter int STOP_CYCLES    = 50000,
  parameter int REVERSE_CYCLES = 200000,
  parameter int TURN_CYCLES    = 150000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       crash,
  input  logic       enable,
  input  logic [9:0] duty,
  output logic       pwm_l,
  output logic       pwm_r,
  output logic [1:0] dir_l,
  output logic [1:0] dir_r,
  output logic [2:0] state,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FORWARD = 3'd1,
    S_STOP    = 3'd2,
    S_REVERSE = 3'd3,
    S_TURN    = 3'd4
  } state_t;

  localparam int PWM_W     = (PWM_PERIOD > 1) ? $clog2(PWM_PERIOD) : 1;
  localparam int FILT_W    = $clog2(CRASH_FILTER + 1);
  localparam int DWELL_MAX = (STOP_CYCLES > REVERSE_CYCLES)
                             ? ((STOP_CYCLES > TURN_CYCLES) ? STOP_CYCLES : TURN_CYCLES)
                             : ((REVERSE_CYCLES > TURN_CYCLES) ? REVERSE_CYCLES : TURN_CYCLES);
  localparam int DWELL_W   = (DWELL_MAX > 1) ? $clog2(DWELL_MAX) : 1;

  localparam logic [PWM_W-1:0]   PWM_LAST  = PWM_W'(PWM_PERIOD - 1);
  localparam logic [FILT_W-1:0]  FILT_MAX  = FILT_W'(CRASH_FILTER);
  localparam logic [DWELL_W-1:0] STOP_LAST = DWELL_W'(STOP_CYCLES - 1);
  localparam logic [DWELL_W-1:0] REV_LAST  = DWELL_W'(REVERSE_CYCLES - 1);
  localparam logic [DWELL_W-1:0] TURN_LAST = DWELL_W'(TURN_CYCLES - 1);

  state_t              cur_state;
  state_t              nxt_state;
  logic [FILT_W-1:0]   filt_cnt;
  logic                crash_ok;
  logic [DWELL_W-1:0]  dwell_cnt;
  logic [PWM_W-1:0]    pwm_cnt;
  logic [9:0]          duty_latched;
  logic                pwm_level;

  function automatic logic [FILT_W-1:0] sat_inc(input logic [FILT_W-1:0] v);
    return (v == FILT_MAX) ? v : v + FILT_W'(1);
  endfunction

  function automatic logic pwm_on(input logic [PWM_W-1:0] cnt, input logic [9:0] d);
    return 32'(cnt) < 32'(d);
  endfunction

  function automatic logic is_busy(input state_t s);
    return (s == S_STOP) || (s == S_REVERSE) || (s == S_TURN);
  endfunction

  function automatic logic drives(input state_t s);
    return (s == S_FORWARD) || (s == S_REVERSE) || (s == S_TURN);
  endfunction

  // {dir_l, dir_r}; 10 forward, 01 reverse, 00 brake
  function automatic logic [3:0] dir_for(input state_t s);
    case (s)
      S_FORWARD: return 4'b10_10;
      S_REVERSE: return 4'b01_01;
      S_TURN:    return 4'b01_10;
      default:   return 4'b00_00;
    endcase
  endfunction

  always_ff @(posedge clock or posedge reset) begin
    if (reset)       filt_cnt <= '0;
    else if (!crash) filt_cnt <= '0;
    else             filt_cnt <= sat_inc(filt_cnt);
  end

  assign crash_ok = (filt_cnt == FILT_MAX);

  always_comb begin
    nxt_state = cur_state;
    case (cur_state)
      S_IDLE:    if (enable) nxt_state = S_FORWARD;
      S_FORWARD: if (crash_ok) nxt_state = S_STOP;
      S_STOP:    if (dwell_cnt == STOP_LAST) nxt_state = S_REVERSE;
      S_REVERSE: if (dwell_cnt == REV_LAST) nxt_state = S_TURN;
      S_TURN: begin
        // A crash during the turn, even on its last cycle, restarts the brake.
        if (crash_ok)                     nxt_state = S_STOP;
        else if (dwell_cnt == TURN_LAST)  nxt_state = S_FORWARD;
      end
      default:   nxt_state = S_IDLE;
    endcase
    if (!enable) nxt_state = S_IDLE;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)                         dwell_cnt <= '0;
    else if (nxt_state != cur_state)   dwell_cnt <= '0;
    else if (is_busy(cur_state))       dwell_cnt <= dwell_cnt + DWELL_W'(1);
    else                               dwell_cnt <= '0;
  end

  // PWM timebase free-runs across state changes; duty only updates on wrap.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pwm_cnt      <= '0;
      duty_latched <= '0;
    end else if (pwm_cnt == PWM_LAST) begin
      pwm_cnt      <= '0;
      duty_latched <= duty;
    end else begin
      pwm_cnt      <= pwm_cnt + PWM_W'(1);
    end
  end

  assign pwm_level = drives(cur_state) && pwm_on(pwm_cnt, duty_latched);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cur_state <= S_IDLE;
      busy      <= 1'b0;
      dir_l     <= 2'b00;
      dir_r     <= 2'b00;
      pwm_l     <= 1'b0;
      pwm_r     <= 1'b0;
    end else begin
      cur_state      <= nxt_state;
      busy           <= is_busy(nxt_state);
      {dir_l, dir_r} <= dir_for(cur_state);
      pwm_l          <= pwm_level;
      pwm_r          <= pwm_level;
    end
  end

  assign state = cur_state;

endmodule

// File: tb/tb_collision_avoidance.sv
// Scoreboard bench for collision_avoidance: the stimulus pushes the expected
// output word per clock, a negedge monitor pops and compares.
module tb_collision_avoidance;

  localparam logic [2:0] S_IDLE = 3'd0, S_FWD = 3'd1, S_STOP = 3'd2,
                         S_REV = 3'd3, S_TURN = 3'd4;

  logic       clock, reset, crash, enable;
  logic [9:0] duty;
  logic       pwm_l, pwm_r, busy;
  logic [1:0] dir_l, dir_r;
  logic [2:0] state;

  collision_avoidance #(
    .PWM_PERIOD(10), .CRASH_FILTER(3), .STOP_CYCLES(5),
    .REVERSE_CYCLES(8), .TURN_CYCLES(6)
  ) dut (
    .clock(clock), .reset(reset), .crash(crash), .enable(enable), .duty(duty),
    .pwm_l(pwm_l), .pwm_r(pwm_r), .dir_l(dir_l), .dir_r(dir_r),
    .state(state), .busy(busy)
  );

  typedef struct packed {
    logic [2:0] st;
    logic       bsy;
    logic [1:0] dl;
    logic [1:0] dr;
    logic       pw;
  } exp_t;

  exp_t       exp_q[$];
  int         checks = 0;
  int         errors = 0;
  int         c = 0;        // clock edges since reset release
  int         dlat = 0;     // duty value the PWM is currently using
  logic [2:0] prev_st = S_IDLE;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("state", 32'(state), 32'(e.st));
      check("busy",  32'(busy),  32'(e.bsy));
      check("dir_l", 32'(dir_l), 32'(e.dl));
      check("dir_r", 32'(dir_r), 32'(e.dr));
      check("pwm_l", 32'(pwm_l), 32'(e.pw));
      check("pwm_r", 32'(pwm_r), 32'(e.pw));
    end
  end

  // One rising edge with the current inputs; es is the state expected after it.
  // Direction and PWM reflect the state held before the edge.
  task automatic step(input logic [2:0] es);
    exp_t e;
    logic drv;
    @(posedge clock);
    #1;
    drv   = (prev_st == S_FWD) || (prev_st == S_REV) || (prev_st == S_TURN);
    e.st  = es;
    e.bsy = (es == S_STOP) || (es == S_REV) || (es == S_TURN);
    case (prev_st)
      S_FWD:   begin e.dl = 2'b10; e.dr = 2'b10; end
      S_REV:   begin e.dl = 2'b01; e.dr = 2'b01; end
      S_TURN:  begin e.dl = 2'b01; e.dr = 2'b10; end
      default: begin e.dl = 2'b00; e.dr = 2'b00; end
    endcase
    e.pw = drv && ((c % 10) < dlat);
    if ((c % 10) == 9) dlat = int'(duty);
    c++;
    prev_st = es;
    exp_q.push_back(e);
  endtask

  task automatic steps(input int n, input logic [2:0] es);
    for (int i = 0; i < n; i++) step(es);
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; crash = 1'b0; duty = 10'd4;
    steps(3, S_IDLE);
    reset = 1'b0; c = 0; dlat = 0; enable = 1'b1;

    // Cruise forward at duty 4
    steps(30, S_FWD);

    // Two-cycle crash pulses are filtered out
    for (int p = 0; p < 2; p++) begin
      crash = 1'b1; steps(2, S_FWD);
      crash = 1'b0; steps(1, S_FWD);
    end

    // Accepted crash, with a crash during REVERSE that must be ignored
    crash = 1'b1; steps(3, S_FWD);
    crash = 1'b0; steps(5, S_STOP);
    steps(1, S_REV);
    crash = 1'b1; steps(3, S_REV);
    crash = 1'b0; steps(4, S_REV);
    steps(6, S_TURN);
    steps(5, S_FWD);

    // Crash during TURN restarts the brake dwell
    crash = 1'b1; steps(3, S_FWD);
    crash = 1'b0; steps(5, S_STOP);
    steps(8, S_REV);
    steps(1, S_TURN);
    crash = 1'b1; steps(3, S_TURN);
    crash = 1'b0; steps(5, S_STOP);
    steps(8, S_REV);

    // crash_ok arriving on the last TURN cycle goes to STOP, not FORWARD
    steps(3, S_TURN);
    crash = 1'b1; steps(3, S_TURN);
    crash = 1'b0; steps(5, S_STOP);

    // Enable dropped in REVERSE
    steps(3, S_REV);
    enable = 1'b0; steps(3, S_IDLE);

    // Duty changes: mid-period change, zero, and over-range
    enable = 1'b1; steps(1, S_FWD);
    for (int k = 0; k < 10 && (c % 10) != 4; k++) step(S_FWD);
    duty = 10'd7;  steps(25, S_FWD);
    duty = 10'd0;  steps(20, S_FWD);
    duty = 10'd15; steps(20, S_FWD);

    // Reset pulse in TURN aborts the manoeuvre at once
    duty = 10'd4;
    crash = 1'b1; steps(3, S_FWD);
    crash = 1'b0; steps(5, S_STOP);
    steps(8, S_REV);
    steps(2, S_TURN);
    @(negedge clock);
    #1;
    reset = 1'b1;
    #1;
    check("async_state", 32'(state), 32'(S_IDLE));
    check("async_busy",  32'(busy),  32'd0);
    check("async_dir_l", 32'(dir_l), 32'd0);
    check("async_dir_r", 32'(dir_r), 32'd0);
    check("async_pwm_l", 32'(pwm_l), 32'd0);
    check("async_pwm_r", 32'(pwm_r), 32'd0);
    prev_st = S_IDLE;
    steps(2, S_IDLE);
    reset = 1'b0; c = 0; dlat = 0;
    steps(14, S_FWD);

    @(negedge clock);
    #2;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
